// File: rtl/sync_fwft_prog_full_fifo.sv
// Single-clock FWFT FIFO with a programmable-full flag.
// The memory has a synchronous read port that feeds a registered head-word output stage.
module sync_fwft_prog_full_fifo #(
    parameter int unsigned DATA_WIDTH       = 128,
    parameter int unsigned DEPTH            = 2048,
    parameter int unsigned PROG_FULL_THRESH = 2000
) (
    input  logic                  clk,
    input  logic                  srst_n,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  prog_full,
    output logic                  empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] dout_q;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] occ_q, occ_d;
    logic          ov_q, ov_d;
    logic          full_q, full_d;
    logic          prog_full_q, prog_full_d;
    logic          empty_q, empty_d;

    logic          pop_c;
    logic          wr_acc_c;
    logic          load_c;
    logic [CW-1:0] mem_cnt_c;

    // Next-state logic. occ includes the output stage (ov_q); mem_cnt_c is what remains in RAM.
    always_comb begin
        pop_c       = rd_en && ov_q;
        wr_acc_c    = wr_en && (!full_q || pop_c);
        mem_cnt_c   = occ_q - CW'(ov_q);
        load_c      = (mem_cnt_c != '0) && (!ov_q || pop_c);

        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occ_d       = occ_q;
        ov_d        = ov_q;

        if (wr_acc_c) wr_ptr_d = wr_ptr_q + AW'(1);
        if (load_c)   rd_ptr_d = rd_ptr_q + AW'(1);

        unique case ({wr_acc_c, pop_c})
            2'b10:   occ_d = occ_q + CW'(1);
            2'b01:   occ_d = occ_q - CW'(1);
            default: occ_d = occ_q;
        endcase

        if (load_c)     ov_d = 1'b1;
        else if (pop_c) ov_d = 1'b0;

        full_d      = (occ_d == CW'(DEPTH));
        prog_full_d = (occ_d >= CW'(PROG_FULL_THRESH));
        empty_d     = !ov_d;
    end

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            ov_q        <= 1'b0;
            full_q      <= 1'b0;
            prog_full_q <= 1'b0;
            empty_q     <= 1'b1;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            ov_q        <= ov_d;
            full_q      <= full_d;
            prog_full_q <= prog_full_d;
            empty_q     <= empty_d;
        end
    end

    // RAM array: write port, no reset on contents.
    always_ff @(posedge clk) begin
        if (srst_n && wr_acc_c) mem[wr_ptr_q] <= din;
    end

    // Synchronous read straight into the head-word register.
    always_ff @(posedge clk) begin
        if (!srst_n)     dout_q <= '0;
        else if (load_c) dout_q <= mem[rd_ptr_q];
    end

    assign dout      = dout_q;
    assign full      = full_q;
    assign prog_full = prog_full_q;
    assign empty     = empty_q;

endmodule

// File: tb/tb_sync_fwft_prog_full_fifo.sv
// Directed self-checking bench for sync_fwft_prog_full_fifo (DEPTH=16, PROG_FULL_THRESH=12).
module tb_sync_fwft_prog_full_fifo;

    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          srst_n;
    logic [DW-1:0] din;
    logic          wr_en;
    logic          rd_en;
    logic [DW-1:0] dout;
    logic          full;
    logic          prog_full;
    logic          empty;

    int checks = 0;
    int errors = 0;

    sync_fwft_prog_full_fifo #(
        .DATA_WIDTH      (DW),
        .DEPTH           (16),
        .PROG_FULL_THRESH(12)
    ) dut (
        .clk      (clk),
        .srst_n   (srst_n),
        .din      (din),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .dout     (dout),
        .full     (full),
        .prog_full(prog_full),
        .empty    (empty)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock edge with the given inputs; returns #1 after the edge with inputs idle.
    task automatic cyc(input logic rst_n_v, input logic w, input logic r, input logic [DW-1:0] d);
        srst_n = rst_n_v;
        wr_en  = w;
        rd_en  = r;
        din    = d;
        @(posedge clk);
        #1;
        srst_n = 1'b1;
        wr_en  = 1'b0;
        rd_en  = 1'b0;
        din    = '0;
    endtask

    initial begin
        logic [DW-1:0] reuse [4];
        srst_n = 1'b0;
        wr_en  = 1'b0;
        rd_en  = 1'b0;
        din    = '0;

        // Reset then idle
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, '0);
        check_eq("rst_empty", DW'(empty), 1);
        check_eq("rst_full", DW'(full), 0);
        check_eq("rst_pfull", DW'(prog_full), 0);
        check_eq("rst_dout", dout, 0);
        cyc(1'b1, 1'b0, 1'b1, '0);
        cyc(1'b1, 1'b0, 1'b1, '0);
        check_eq("idle_rd_empty", DW'(empty), 1);
        check_eq("idle_rd_dout", dout, 0);

        // Ordered FWFT with 2-edge visibility
        cyc(1'b1, 1'b1, 1'b0, 32'h1);
        check_eq("fwft_n_empty", DW'(empty), 1);
        cyc(1'b1, 1'b1, 1'b0, 32'h2);
        check_eq("fwft_n1_empty", DW'(empty), 0);
        check_eq("fwft_n1_dout", dout, 32'h1);
        cyc(1'b1, 1'b1, 1'b0, 32'h3);
        cyc(1'b1, 1'b0, 1'b1, '0);
        check_eq("fwft_pop1", dout, 32'h2);
        cyc(1'b1, 1'b0, 1'b1, '0);
        check_eq("fwft_pop2", dout, 32'h3);
        check_eq("fwft_pop2_empty", DW'(empty), 0);
        cyc(1'b1, 1'b0, 1'b1, '0);
        check_eq("fwft_pop3_empty", DW'(empty), 1);

        // Threshold and full
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 1'b1, 1'b0, DW'(32'h100 + i));
            if (i == 10) check_eq("pf_at_11", DW'(prog_full), 0);
            if (i == 11) check_eq("pf_at_12", DW'(prog_full), 1);
            if (i == 14) check_eq("full_at_15", DW'(full), 0);
        end
        check_eq("full_at_16", DW'(full), 1);
        check_eq("head_at_16", dout, 32'h100);
        cyc(1'b1, 1'b1, 1'b0, 32'hDEAD);
        check_eq("drop_full", DW'(full), 1);
        check_eq("drop_head", dout, 32'h100);

        // Simultaneous pop+write at occ=DEPTH
        cyc(1'b1, 1'b1, 1'b1, 32'h200);
        check_eq("rw_full_full", DW'(full), 1);
        check_eq("rw_full_head", dout, 32'h101);
        for (int i = 0; i < 16; i++) begin
            check_eq("drain_data", dout, (i < 15) ? DW'(32'h101 + i) : 32'h200);
            cyc(1'b1, 1'b0, 1'b1, '0);
            if (i == 0) check_eq("drain_full_off", DW'(full), 0);
            if (i == 3) check_eq("drain_pf_occ12", DW'(prog_full), 1);
            if (i == 4) check_eq("drain_pf_occ11", DW'(prog_full), 0);
        end
        check_eq("drain_empty", DW'(empty), 1);

        // Simultaneous pop+write at occ=1
        cyc(1'b1, 1'b1, 1'b0, 32'h55);
        cyc(1'b1, 1'b0, 1'b0, '0);
        check_eq("occ1_head", dout, 32'h55);
        cyc(1'b1, 1'b1, 1'b1, 32'h66);
        check_eq("occ1_rw_empty", DW'(empty), 1);
        cyc(1'b1, 1'b0, 1'b0, '0);
        check_eq("occ1_vis_empty", DW'(empty), 0);
        check_eq("occ1_vis_dout", dout, 32'h66);
        cyc(1'b1, 1'b0, 1'b1, '0);
        check_eq("occ1_final_empty", DW'(empty), 1);

        // Reuse loop: pop each head word and write it back
        reuse[0] = 32'hA; reuse[1] = 32'hB; reuse[2] = 32'hC; reuse[3] = 32'hD;
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, reuse[i]);
        cyc(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 8; i++) begin
            check_eq("reuse_dout", dout, reuse[i % 4]);
            cyc(1'b1, 1'b1, 1'b1, reuse[i % 4]);
            check_eq("reuse_empty", DW'(empty), 0);
        end
        for (int i = 0; i < 4; i++) begin
            check_eq("reuse_drain", dout, reuse[i]);
            cyc(1'b1, 1'b0, 1'b1, '0);
        end
        check_eq("reuse_occ4_empty", DW'(empty), 1);

        // Reset mid-operation at occ=7
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b1, 1'b0, DW'(32'h300 + i));
        cyc(1'b1, 1'b0, 1'b0, '0);
        check_eq("pre_rst_head", dout, 32'h300);
        cyc(1'b0, 1'b1, 1'b1, 32'h3FF);
        check_eq("mrst_empty", DW'(empty), 1);
        check_eq("mrst_pfull", DW'(prog_full), 0);
        check_eq("mrst_full", DW'(full), 0);
        check_eq("mrst_dout", dout, 0);
        cyc(1'b1, 1'b1, 1'b0, 32'h77);
        check_eq("mrst_w_n_empty", DW'(empty), 1);
        cyc(1'b1, 1'b0, 1'b0, '0);
        check_eq("mrst_w_vis_empty", DW'(empty), 0);
        check_eq("mrst_w_vis_dout", dout, 32'h77);
        cyc(1'b1, 1'b0, 1'b1, '0);
        check_eq("mrst_final_empty", DW'(empty), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
